// File: rtl/eth_hdr_classifier_pkg.sv
// Shared constants and helpers for the Ethernet header classifier and the
// lookup stages that follow it.
package eth_hdr_classifier_pkg;

  localparam logic [15:0] ETHTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETHTYPE_IPV6 = 16'h86DD;
  localparam logic [15:0] ETHTYPE_VLAN = 16'h8100;

  typedef enum logic [1:0] {
    ETHCLASS_OTHER = 2'd0,
    ETHCLASS_IPV4  = 2'd1,
    ETHCLASS_ARP   = 2'd2,
    ETHCLASS_IPV6  = 2'd3
  } ethclass_e;

  // Header field offsets, in bits counted down from the tdata MSB.
  localparam int DMAC_OFS  = 0;
  localparam int ETYPE_OFS = 96;
  localparam int TCI_OFS   = 112;
  localparam int INNER_OFS = 128;

  localparam int SPORT_WIDTH = 8;

  // A nested 0x8100 falls through to OTHER, which is how double tags are reported.
  function automatic ethclass_e ethclass_of(input logic [15:0] etype);
    ethclass_e cls;
    cls = ETHCLASS_OTHER;
    case (etype)
      ETHTYPE_IPV4: cls = ETHCLASS_IPV4;
      ETHTYPE_ARP:  cls = ETHCLASS_ARP;
      ETHTYPE_IPV6: cls = ETHCLASS_IPV6;
      default:      cls = ETHCLASS_OTHER;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/eth_hdr_classifier_sport_decode.sv
// Source-port field decode: one-hot position -> {port index, CPU flag, bad}.
// Even bit positions are MAC ports, odd positions the matching CPU queue.
module eth_sport_decode
  import eth_hdr_classifier_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic [SPORT_WIDTH-1:0] sport,
  output logic [1:0]             port_idx,
  output logic                   from_cpu,
  output logic                   bad
);

  logic [3:0] ones;
  logic [2:0] pos;

  always_comb begin
    ones = '0;
    pos  = '0;
    for (int i = 0; i < SPORT_WIDTH; i++) begin
      if (sport[i]) begin
        ones = ones + 4'd1;
        pos  = 3'(i);
      end
    end
    bad = (ones != 4'd1) || (32'(pos[2:1]) >= NUM_PORTS);
    // A rejected field reports port 0 / not-CPU so downstream never sees a half-valid decode.
    port_idx = bad ? 2'd0 : pos[2:1];
    from_cpu = !bad && pos[0];
  end

endmodule

// File: rtl/eth_hdr_classifier.sv
// Ethernet header classifier: snoops the packet stream, captures the first beat
// of each packet and produces one classification result per packet.
module eth_hdr_classifier
  import eth_hdr_classifier_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS            = 4,
  parameter int MAC_WIDTH            = 48,
  parameter int SRC_PORT_POS         = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  input  logic                              s_axis_tready,
  output logic                              o_hdr_ready,
  input  logic [NUM_PORTS*MAC_WIDTH-1:0]    i_macs,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic                              o_is_for_us,
  output logic                              o_is_bcast,
  output logic                              o_is_mcast,
  output logic                              o_is_vlan,
  output logic [11:0]                       o_vid,
  output logic [1:0]                        o_ethclass,
  output logic                              o_from_cpu,
  output logic [1:0]                        o_port_idx,
  output logic                              o_bad_sport
);

  localparam int TD_MSB    = C_S_AXIS_TDATA_WIDTH - 1;
  localparam int GROUP_BIT = MAC_WIDTH - 8;

  logic                   in_pkt_reg;
  logic                   sop;
  logic                   beat_accept;
  logic                   s2_load;

  logic                   s1_valid_reg;
  logic [MAC_WIDTH-1:0]   s1_dmac_reg;
  logic [15:0]            s1_etype_reg;
  logic [11:0]            s1_vid_reg;
  logic [15:0]            s1_inner_reg;
  logic [SPORT_WIDTH-1:0] s1_sport_reg;

  logic [1:0]             dec_port_idx;
  logic                   dec_from_cpu;
  logic                   dec_bad;
  logic [NUM_PORTS-1:0]   mac_hit;

  logic                   bcast_next;
  logic                   mcast_next;
  logic                   vlan_next;
  logic [11:0]            vid_next;
  ethclass_e              ethclass_next;
  logic                   for_us_next;

  logic                   unused_bits;

  assign sop         = s_axis_tvalid && !in_pkt_reg;
  // Only a SOP can be stalled, and only until both pipeline slots can take it.
  assign o_hdr_ready = !sop || (!s1_valid_reg && (!o_valid || i_ready));
  assign beat_accept = s_axis_tvalid && s_axis_tready && o_hdr_ready;
  assign s2_load     = s1_valid_reg && (!o_valid || i_ready);

  assign unused_bits = ^{s_axis_tdata, s_axis_tuser};

  always_ff @(posedge clk) begin
    if (reset) begin
      in_pkt_reg <= 1'b0;
    end else if (beat_accept) begin
      in_pkt_reg <= !s_axis_tlast;
    end
  end

  // Stage 1: capture the raw header fields of the SOP beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_dmac_reg  <= '0;
      s1_etype_reg <= '0;
      s1_vid_reg   <= '0;
      s1_inner_reg <= '0;
      s1_sport_reg <= '0;
    end else if (beat_accept && sop) begin
      s1_valid_reg <= 1'b1;
      s1_dmac_reg  <= s_axis_tdata[TD_MSB-DMAC_OFS -: MAC_WIDTH];
      s1_etype_reg <= s_axis_tdata[TD_MSB-ETYPE_OFS -: 16];
      s1_vid_reg   <= s_axis_tdata[TD_MSB-TCI_OFS-4 -: 12];
      s1_inner_reg <= s_axis_tdata[TD_MSB-INNER_OFS -: 16];
      s1_sport_reg <= s_axis_tuser[SRC_PORT_POS +: SPORT_WIDTH];
    end else if (s2_load) begin
      s1_valid_reg <= 1'b0;
    end
  end

  eth_sport_decode #(
    .NUM_PORTS (NUM_PORTS)
  ) u_sport_decode (
    .sport    (s1_sport_reg),
    .port_idx (dec_port_idx),
    .from_cpu (dec_from_cpu),
    .bad      (dec_bad)
  );

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_mac_hit
      assign mac_hit[gi] = (dec_port_idx == 2'(gi)) &&
                           (s1_dmac_reg == i_macs[gi*MAC_WIDTH +: MAC_WIDTH]);
    end
  endgenerate

  always_comb begin
    bcast_next    = &s1_dmac_reg;
    mcast_next    = s1_dmac_reg[GROUP_BIT] && !bcast_next;
    vlan_next     = (s1_etype_reg == ETHTYPE_VLAN);
    vid_next      = vlan_next ? s1_vid_reg : 12'd0;
    ethclass_next = vlan_next ? ethclass_of(s1_inner_reg) : ethclass_of(s1_etype_reg);
    // CPU-injected or malformed-source packets are never addressed to us.
    for_us_next   = !dec_bad && !dec_from_cpu && (bcast_next || mcast_next || (|mac_hit));
  end

  // Stage 2: result register with valid/ready handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid     <= 1'b0;
      o_is_for_us <= 1'b0;
      o_is_bcast  <= 1'b0;
      o_is_mcast  <= 1'b0;
      o_is_vlan   <= 1'b0;
      o_vid       <= '0;
      o_ethclass  <= '0;
      o_from_cpu  <= 1'b0;
      o_port_idx  <= '0;
      o_bad_sport <= 1'b0;
    end else if (s2_load) begin
      o_valid     <= 1'b1;
      o_is_for_us <= for_us_next;
      o_is_bcast  <= bcast_next;
      o_is_mcast  <= mcast_next;
      o_is_vlan   <= vlan_next;
      o_vid       <= vid_next;
      o_ethclass  <= ethclass_next;
      o_from_cpu  <= dec_from_cpu;
      o_port_idx  <= dec_port_idx;
      o_bad_sport <= dec_bad;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_eth_hdr_classifier.sv
// Directed bench for eth_hdr_classifier: a packet-level reference model feeds
// an in-order scoreboard, plus literal checks on the directed scenarios.
module tb_eth_hdr_classifier;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] s_axis_tdata;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic         o_hdr_ready;
  logic [191:0] i_macs;
  logic         o_valid;
  logic         i_ready;
  logic         o_is_for_us, o_is_bcast, o_is_mcast, o_is_vlan;
  logic [11:0]  o_vid;
  logic [1:0]   o_ethclass;
  logic         o_from_cpu;
  logic [1:0]   o_port_idx;
  logic         o_bad_sport;

  typedef struct packed {
    logic        for_us;
    logic        bcast;
    logic        mcast;
    logic        vlan;
    logic [11:0] vid;
    logic [1:0]  ethclass;
    logic        from_cpu;
    logic [1:0]  port_idx;
    logic        bad;
  } res_t;

  localparam logic [47:0] MAC0 = 48'h004e46324300;
  localparam logic [47:0] MAC1 = 48'h004e46324301;
  localparam logic [47:0] MAC2 = 48'h004e46324302;
  localparam logic [47:0] MAC3 = 48'h004e46324303;
  localparam logic [47:0] BCAST = 48'hffffffffffff;
  localparam logic [47:0] MCAST = 48'h01005e000001;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  logic tb_in_pkt = 1'b0;
  logic hold = 1'b0;
  res_t held;

  eth_hdr_classifier dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .o_hdr_ready   (o_hdr_ready),
    .i_macs        (i_macs),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_is_for_us   (o_is_for_us),
    .o_is_bcast    (o_is_bcast),
    .o_is_mcast    (o_is_mcast),
    .o_is_vlan     (o_is_vlan),
    .o_vid         (o_vid),
    .o_ethclass    (o_ethclass),
    .o_from_cpu    (o_from_cpu),
    .o_port_idx    (o_port_idx),
    .o_bad_sport   (o_bad_sport)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic logic [255:0] frm(input logic [47:0] dm, input logic [15:0] et,
                                       input logic [15:0] tci, input logic [15:0] inner);
    return {dm, 48'h0a0b0c0d0e0f, et, tci, inner, 112'h0};
  endfunction

  function automatic logic [1:0] cls_of(input logic [15:0] et);
    if (et == 16'h0800) return 2'd1;
    if (et == 16'h0806) return 2'd2;
    if (et == 16'h86DD) return 2'd3;
    return 2'd0;
  endfunction

  // Reference classification straight from the packet-level rules.
  function automatic res_t model(input logic [255:0] d, input logic [7:0] sp, input logic [191:0] macs);
    res_t r;
    logic [47:0] dm;
    logic [15:0] et, tci, inner;
    int pos, port;
    dm = d[255:208]; et = d[159:144]; tci = d[143:128]; inner = d[127:112];
    r = '0;
    r.bad = ($countones(sp) != 1);
    pos = r.bad ? 0 : $clog2(sp);
    port = pos / 2;
    if (port >= 4) r.bad = 1'b1;
    r.port_idx = r.bad ? 2'd0 : 2'(port);
    r.from_cpu = !r.bad && (pos % 2 == 1);
    r.bcast = (dm == 48'hffffffffffff);
    r.mcast = (dm[40] == 1'b1) && !r.bcast;
    r.vlan = (et == 16'h8100);
    r.vid = r.vlan ? tci[11:0] : 12'd0;
    r.ethclass = r.vlan ? cls_of(inner) : cls_of(et);
    r.for_us = !r.bad && !r.from_cpu &&
               (r.bcast || r.mcast || dm == macs[48*port +: 48]);
    return r;
  endfunction

  function automatic res_t dut_res();
    return {o_is_for_us, o_is_bcast, o_is_mcast, o_is_vlan, o_vid, o_ethclass,
            o_from_cpu, o_port_idx, o_bad_sport};
  endfunction

  // Scoreboard: predict on every accepted SOP, retire on every handshake.
  always @(negedge clk) begin
    res_t act;
    res_t e;
    if (reset) begin
      exp_q.delete();
      tb_in_pkt = 1'b0;
      hold = 1'b0;
    end else begin
      act = dut_res();
      if (hold) begin
        chk("hold_valid", 32'(o_valid), 32'd1);
        chk("hold_stable", 32'(act), 32'(held));
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_result", 32'(act), 32'hffffffff);
        end else begin
          e = exp_q.pop_front();
          chk("result", 32'(act), 32'(e));
        end
      end
      hold = o_valid && !i_ready;
      held = act;
      if (s_axis_tvalid && tb_in_pkt) chk("nonsop_ready", 32'(o_hdr_ready), 32'd1);
      if (s_axis_tvalid && s_axis_tready && o_hdr_ready) begin
        if (!tb_in_pkt) exp_q.push_back(model(s_axis_tdata, s_axis_tuser[23:16], i_macs));
        tb_in_pkt = !s_axis_tlast;
      end
    end
  end

  // Present one beat and hold it until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [255:0] d, input logic [7:0] sp, input logic last);
    int waited;
    waited = 0;
    s_axis_tdata  = d;
    s_axis_tuser  = 128'(sp) << 16;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (o_hdr_ready) break;
      waited++;
      if (waited > 50) begin
        chk("accept_timeout", 32'(o_hdr_ready), 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Single-beat packet into an empty pipeline: result must appear two cycles on.
  task automatic pkt(input string name, input logic [255:0] d, input logic [7:0] sp);
    send(d, sp, 1'b1);
    chk({name, "_lat_n1"}, 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    chk({name, "_lat_n2"}, 32'(o_valid), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    s_axis_tdata = '0; s_axis_tuser = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tready = 1'b1;
    i_ready = 1'b1;
    i_macs = {MAC3, MAC2, MAC1, MAC0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", 32'({o_valid, dut_res()}), 32'd0);
    chk("rst_hdr_ready", 32'(o_hdr_ready), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Unicast to our port-0 MAC, IPv4.
    pkt("t1", frm(MAC0, 16'h0800, 16'h0, 16'h0), 8'h01);
    chk("t1_for_us", 32'(o_is_for_us), 32'd1);
    chk("t1_ethclass", 32'(o_ethclass), 32'd1);
    chk("t1_port_idx", 32'(o_port_idx), 32'd0);
    @(posedge clk); #1;

    // Broadcast ARP from port 2, then multicast.
    pkt("t2b", frm(BCAST, 16'h0806, 16'h0, 16'h0), 8'h10);
    chk("t2_bcast", 32'({o_is_bcast, o_is_mcast, o_is_for_us}), 32'b101);
    chk("t2_ethclass", 32'(o_ethclass), 32'd2);
    chk("t2_port_idx", 32'(o_port_idx), 32'd2);
    @(posedge clk); #1;
    pkt("t2m", frm(MCAST, 16'h0800, 16'h0, 16'h0), 8'h10);
    chk("t2_mcast", 32'({o_is_bcast, o_is_mcast, o_is_for_us}), 32'b011);
    @(posedge clk); #1;

    // Unicast to another port's MAC is not for us.
    pkt("t2u", frm(MAC1, 16'h0800, 16'h0, 16'h0), 8'h01);
    chk("t2_other_mac", 32'(o_is_for_us), 32'd0);
    @(posedge clk); #1;

    // VLAN tagged IPv6, then double tag.
    pkt("t3v", frm(MAC0, 16'h8100, 16'h2064, 16'h86DD), 8'h01);
    chk("t3_vlan", 32'({o_is_vlan, o_vid, o_ethclass}), {17'd0, 1'b1, 12'h064, 2'd3});
    @(posedge clk); #1;
    pkt("t3q", frm(MAC0, 16'h8100, 16'h0fff, 16'h8100), 8'h01);
    chk("t3_qinq", 32'({o_is_vlan, o_vid, o_ethclass}), {17'd0, 1'b1, 12'hfff, 2'd0});
    @(posedge clk); #1;

    // Malformed source field, then CPU source.
    pkt("t4b", frm(MAC0, 16'h0800, 16'h0, 16'h0), 8'h05);
    chk("t4_bad", 32'({o_bad_sport, o_is_for_us}), 32'b10);
    @(posedge clk); #1;
    pkt("t4c", frm(MAC0, 16'h0800, 16'h0, 16'h0), 8'h02);
    chk("t4_cpu", 32'({o_from_cpu, o_port_idx, o_is_for_us, o_bad_sport}), 32'b10000);
    @(posedge clk); #1;

    // Multi-beat packet: only the first beat is classified.
    send(frm(MAC3, 16'h0806, 16'h0, 16'h0), 8'h40, 1'b0);
    send(frm(BCAST, 16'h86DD, 16'h0, 16'h0), 8'h01, 1'b0);
    send(frm(MCAST, 16'h0800, 16'h0, 16'h0), 8'h01, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_multibeat_drained", 32'(exp_q.size()), 32'd0);

    // Back-to-back single-beat packets with the result sink stalled.
    i_ready = 1'b0;
    send(frm(MAC0, 16'h0800, 16'h0, 16'h0), 8'h01, 1'b1);
    s_axis_tdata  = frm(BCAST, 16'h0806, 16'h0, 16'h0);
    s_axis_tuser  = 128'(8'h04) << 16;
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    chk("t5_block_s1", 32'(o_hdr_ready), 32'd0);
    @(negedge clk);
    chk("t5_block_out", 32'({o_valid, o_hdr_ready}), 32'b10);
    repeat (3) @(negedge clk);
    chk("t5_still_blocked", 32'({o_valid, o_hdr_ready}), 32'b10);
    @(posedge clk); #1;
    i_ready = 1'b1;
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    send(frm(MAC2, 16'h86DD, 16'h0, 16'h0), 8'h10, 1'b1);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("t5_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    chk("t5_idle", 32'(o_valid), 32'd0);

    // Reset mid-packet: the following beat must be treated as a new SOP.
    send(frm(MAC1, 16'h0800, 16'h0, 16'h0), 8'h04, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_rst_outputs", 32'({o_valid, dut_res()}), 32'd0);
    chk("t6_rst_hdr_ready", 32'(o_hdr_ready), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    pkt("t6", frm(BCAST, 16'h0806, 16'h0, 16'h0), 8'h04);
    chk("t6_sop_after_rst", 32'({o_is_bcast, o_port_idx, o_ethclass}), 32'b10110);
    repeat (3) @(posedge clk);
    #1;
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
